sc_ifetch: RTL and testbench

SC_IFETCH -- requirements
Module: sc_ifetch

---
 rtl/sc_pkg.sv | 24 ++
 rtl/sc_next_pc.sv | 29 ++
 rtl/sc_ifetch.sv | 110 +++++++++++
 tb/tb_sc_ifetch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared definitions for the single-cycle CPU front end: next-PC select
// encodings, fetch FSM state encodings, default reset vector and the
// branch-offset helper.
package sc_pkg;

   typedef logic [1:0] pcsel_t;

   localparam pcsel_t PCS_SEQ = 2'b00;
   localparam pcsel_t PCS_BR  = 2'b01;
   localparam pcsel_t PCS_JR  = 2'b10;
   localparam pcsel_t PCS_J   = 2'b11;

   localparam logic [1:0] ST_FETCH = 2'b00;
   localparam logic [1:0] ST_HOLD  = 2'b01;
   localparam logic [1:0] ST_FAULT = 2'b10;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Word offset of a branch immediate, as a byte displacement
   function automatic logic [31:0] branch_off(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/sc_next_pc.sv
// Combinational next-PC selection: sequential, PC-relative branch,
// register-indirect jump and pseudo-absolute jump.
module sc_next_pc
   import sc_pkg::*;
(
   input  logic [1:0]  pcsource,
   input  logic [31:0] p4,
   input  logic [31:0] inst,
   input  logic [31:0] ra,
   output logic [31:0] next_pc
);

   // The opcode field is decoded elsewhere; only immediates are used here
   logic unused_inst_hi;
   assign unused_inst_hi = &{1'b0, inst[31:26]};

   // Select the target according to the control unit's request
   always_comb begin
      next_pc = p4;
      case (pcsource)
         PCS_SEQ: next_pc = p4;
         PCS_BR:  next_pc = p4 + branch_off(inst[15:0]);
         PCS_JR:  next_pc = ra;
         PCS_J:   next_pc = {p4[31:28], inst[25:0], 2'b00};
         default: next_pc = p4;
      endcase
   end

endmodule

// File: rtl/sc_ifetch.sv
// Instruction fetch unit. Requests the word at pc, waits for imem_ready
// (with a bounded wait and a one-cycle request drop before retrying),
// holds the fetched instruction until execute retires it, then moves pc
// to the selected next address.
// Optional feature: define IFETCH_ALIGN_CHK_EN to trap misaligned targets
// into a sticky FAULT state; otherwise targets are forced word-aligned.
module sc_ifetch
   import sc_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
   parameter int          IMEM_TIMEOUT = 15
)(
   input  logic        clock,
   input  logic        resetn,
   input  logic [1:0]  pcsource,
   input  logic [31:0] ra,
   input  logic        advance,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic [31:0] pc,
   output logic [31:0] p4,
   output logic        fault
);

   localparam int CNT_W = $clog2(IMEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_TIMEOUT - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] wait_cnt;
   logic             retry_gap;
   logic [31:0]      target;
   logic [31:0]      next_pc;

   assign p4 = pc + 32'd4;

   sc_next_pc u_next_pc (
      .pcsource (pcsource),
      .p4       (p4),
      .inst     (inst),
      .ra       (ra),
      .next_pc  (target)
   );

`ifdef IFETCH_ALIGN_CHK_EN
   assign next_pc = target;
   assign fault   = (state == ST_FAULT);
`else
   assign next_pc = target & 32'hFFFF_FFFC;
   assign fault   = 1'b0;
`endif

   // Request is dropped for the single retry-gap cycle after a timeout
   assign imem_req   = (state == ST_FETCH) && !retry_gap;
   assign imem_addr  = pc;
   assign inst_valid = (state == ST_HOLD);

   // Fetch FSM, pc, wait counter and instruction latch
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_FETCH;
         pc        <= RESET_PC;
         inst      <= '0;
         wait_cnt  <= '0;
         retry_gap <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (retry_gap) begin
                  retry_gap <= 1'b0;
               end else if (imem_ready) begin
                  inst     <= imem_rdata;
                  wait_cnt <= '0;
                  state    <= ST_HOLD;
               end else if (wait_cnt == CNT_LAST) begin
                  retry_gap <= 1'b1;
                  wait_cnt  <= '0;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (advance) begin
`ifdef IFETCH_ALIGN_CHK_EN
                  if (|next_pc[1:0]) begin
                     state <= ST_FAULT;
                  end else begin
                     pc    <= next_pc;
                     state <= ST_FETCH;
                  end
`else
                  pc    <= next_pc;
                  state <= ST_FETCH;
`endif
               end
            end
            ST_FAULT: begin
               state <= ST_FAULT;
            end
            default: begin
               state <= ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sc_ifetch.sv
// Self-checking bench for sc_ifetch: reset behaviour, table of next-PC
// cases, fetch timeout/retry, reset mid-fetch, misaligned jr target and
// randomized fetch/advance traffic against a reference model.
module tb_sc_ifetch;
   import sc_pkg::*;

   localparam logic [31:0] RPC = 32'h0000_0000;
   localparam int          TO  = 15;

   logic        clock      = 1'b0;
   logic        resetn     = 1'b0;
   logic [1:0]  pcsource   = 2'b00;
   logic [31:0] ra         = '0;
   logic        advance    = 1'b0;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] inst;
   logic        inst_valid;
   logic [31:0] pc;
   logic [31:0] p4;
   logic        fault;

   int checks = 0;
   int errors = 0;
   logic [31:0] mpc;
   logic [31:0] last_iw;

   sc_ifetch #(.RESET_PC(RPC), .IMEM_TIMEOUT(TO)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .pcsource   (pcsource),
      .ra         (ra),
      .advance    (advance),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .inst       (inst),
      .inst_valid (inst_valid),
      .pc         (pc),
      .p4         (p4),
      .fault      (fault)
   );

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] pc;
      logic [31:0] iw;
      logic [1:0]  sel;
      logic [31:0] rv;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Target address from the architectural rules, in plain arithmetic
   function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] iw,
                                              input logic [1:0] sel, input logic [31:0] rv);
      logic [31:0] r;
      int off;
      case (sel)
         2'd0: r = cur + 32'd4;
         2'd1: begin
            off = int'($signed(iw[15:0])) * 4;
            r = cur + 32'd4 + 32'(off);
         end
         2'd2: r = rv;
         default: r = ((cur + 32'd4) & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) * 4);
      endcase
`ifndef IFETCH_ALIGN_CHK_EN
      r = r & 32'hFFFF_FFFC;
`endif
      return r;
   endfunction

   // Wait 'delay' cycles without ready, then deliver 'word'; ends in HOLD
   task automatic fetch(input logic [31:0] word, input int delay, input logic [31:0] exp_pc, input bit noisy);
      for (int i = 0; i < delay; i++) begin
         chk("req_wait", imem_req, 1);
         chk("addr_wait", imem_addr, exp_pc);
         imem_ready = 1'b0;
         if (noisy) begin
            advance  = 1'($urandom_range(0, 1));
            pcsource = 2'($urandom);
            ra       = $urandom;
         end
         tick();
      end
      advance = 1'b0;
      chk("req_fetch", imem_req, 1);
      chk("addr_fetch", imem_addr, exp_pc);
      imem_ready = 1'b1;
      imem_rdata = word;
      tick();
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      last_iw = word;
      chk("inst", inst, word);
      chk("inst_valid", inst_valid, 1);
      chk("hold_req", imem_req, 0);
      chk("pc_hold", pc, exp_pc);
   endtask

   task automatic adv(input logic [1:0] sel, input logic [31:0] rv);
      pcsource = sel;
      ra       = rv;
      advance  = 1'b1;
      tick();
      advance  = 1'b0;
   endtask

   task automatic goto_pc(input logic [31:0] target);
      adv(PCS_JR, target);
      chk("goto_addr", imem_addr, target);
      mpc = target;
   endtask

   initial begin
      logic [1:0]  sel;
      logic [31:0] rv;
      logic [31:0] expn;
      logic [31:0] w;

      vecs[0] = '{32'h0000_0100, 32'h0000_FFFE, PCS_BR,  32'h0,         32'h0000_00FC};
      vecs[1] = '{32'h3000_0010, 32'h0800_0010, PCS_J,   32'h0,         32'h3000_0040};
      vecs[2] = '{32'hFFFF_FFFC, 32'h0000_0000, PCS_SEQ, 32'h0,         32'h0000_0000};
      vecs[3] = '{32'h0000_1000, 32'h1000_0010, PCS_BR,  32'h0,         32'h0000_1044};
      vecs[4] = '{32'h0000_0040, 32'h0000_8000, PCS_BR,  32'h0,         32'hFFFE_0044};
      vecs[5] = '{32'h2FFF_FFFC, 32'h0BFF_FFFF, PCS_J,   32'h0,         32'h3FFF_FFFC};
      vecs[6] = '{32'h0000_0080, 32'h1234_5678, PCS_JR,  32'hDEAD_BEE0, 32'hDEAD_BEE0};
      vecs[7] = '{32'h7FFF_FFF8, 32'h0000_0000, PCS_SEQ, 32'h0,         32'h7FFF_FFFC};

      // Reset state
      resetn = 1'b0;
      repeat (3) tick();
      chk("rst_pc", pc, RPC);
      chk("rst_inst", inst, 0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_fault", fault, 0);

      // First request right after release, ready in cycle 2
      resetn = 1'b1;
      chk("first_req", imem_req, 1);
      chk("first_addr", imem_addr, RPC);
      fetch(32'h2008_0005, 1, RPC, 0);
      chk("first_p4", p4, RPC + 32'd4);
      mpc = RPC;

      // Table of next-PC cases
      for (int v = 0; v < 8; v++) begin
         goto_pc(vecs[v].pc);
         fetch(vecs[v].iw, 0, vecs[v].pc, 0);
         chk("vec_p4", p4, vecs[v].pc + 32'd4);
         adv(vecs[v].sel, vecs[v].rv);
         chk("vec_addr", imem_addr, vecs[v].exp);
         chk("vec_pc", pc, vecs[v].exp);
         mpc = vecs[v].exp;
         fetch($urandom, 0, mpc, 0);
      end

      // Timeout: 15 request cycles, one dropped cycle, then re-request
      adv(PCS_SEQ, 32'h0);
      mpc = mpc + 32'd4;
      for (int i = 0; i < TO; i++) begin
         chk("to_req", imem_req, 1);
         chk("to_addr", imem_addr, mpc);
         pcsource = PCS_JR;
         ra       = 32'h40;
         advance  = 1'b1;
         tick();
      end
      advance = 1'b0;
      chk("to_gap_req", imem_req, 0);
      chk("to_gap_pc", pc, mpc);
      tick();
      chk("to_retry_req", imem_req, 1);
      chk("to_retry_addr", imem_addr, mpc);
      fetch(32'h0000_0001, 0, mpc, 0);

      // Randomized traffic against the reference model
      for (int it = 0; it < 40; it++) begin
         if (($urandom & 1) != 0) begin
            imem_ready = 1'b1;
            imem_rdata = ~last_iw;
            tick();
            imem_ready = 1'b0;
            chk("hold_inst_stable", inst, last_iw);
            chk("hold_valid", inst_valid, 1);
         end
         sel = 2'($urandom);
         rv  = $urandom;
`ifdef IFETCH_ALIGN_CHK_EN
         rv = rv & 32'hFFFF_FFFC;
`endif
         expn = model_next(mpc, last_iw, sel, rv);
         adv(sel, rv);
         chk("rnd_addr", imem_addr, expn);
         mpc = expn;
         w = $urandom;
         fetch(w, int'($urandom_range(0, 12)), mpc, 1);
         chk("rnd_p4", p4, mpc + 32'd4);
      end

      // Reset in the middle of a pending fetch
      goto_pc(32'h0000_0500);
      tick();
      resetn = 1'b0;
      #1;
      chk("mid_rst_pc", pc, RPC);
      chk("mid_rst_inst", inst, 0);
      imem_ready = 1'b1;
      imem_rdata = 32'h0BAD_0BAD;
      tick();
      tick();
      imem_ready = 1'b0;
      resetn = 1'b1;
      chk("post_rst_inst", inst, 0);
      chk("post_rst_valid", inst_valid, 0);
      chk("post_rst_req", imem_req, 1);
      chk("post_rst_addr", imem_addr, RPC);
      fetch(32'h0000_0002, 0, RPC, 0);
      mpc = RPC;

      // Misaligned jr target
      goto_pc(32'h0000_0300);
      fetch(32'h0000_0003, 0, 32'h0000_0300, 0);
      adv(PCS_JR, 32'h0000_0202);
`ifdef IFETCH_ALIGN_CHK_EN
      chk("mis_fault", fault, 1);
      chk("mis_req", imem_req, 0);
      chk("mis_valid", inst_valid, 0);
      chk("mis_pc", pc, 32'h0000_0300);
      for (int i = 0; i < 3; i++) begin
         imem_ready = 1'b1;
         advance    = 1'b1;
         pcsource   = PCS_SEQ;
         tick();
         chk("fault_req", imem_req, 0);
         chk("fault_sticky", fault, 1);
      end
      imem_ready = 1'b0;
      advance    = 1'b0;
      resetn = 1'b0;
      tick();
      chk("fault_clr", fault, 0);
      resetn = 1'b1;
      chk("fault_rst_req", imem_req, 1);
      chk("fault_rst_addr", imem_addr, RPC);
`else
      chk("mis_addr", imem_addr, 32'h0000_0200);
      chk("mis_fault", fault, 0);
      chk("mis_req", imem_req, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
